// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM access stage.
// The SUBWORD_ACCESS_EN macro decides whether the size encodings are honoured.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store replication, load extraction/extension.
// With SUBWORD_ACCESS_EN undefined every access is treated as a full word.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsignedLd,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_storeData,
    input  logic [31:0] i_rData,
    output logic [3:0]  o_be,
    output logic [31:0] o_wData,
    output logic [31:0] o_loadData,
    output logic        o_misaligned
);

`ifdef SUBWORD_ACCESS_EN
    logic [31:0] w_shifted;

    // Move the addressed lane down to bit 0 before extension.
    assign w_shifted = i_rData >> {i_addrLo, 3'b000};

    always_comb begin
        o_be         = BE_WORD;
        o_wData      = i_storeData;
        o_loadData   = i_rData;
        o_misaligned = (i_addrLo != 2'b00);
        case (i_size)
            SZ_HALF: begin
                o_be         = i_addrLo[1] ? BE_HALF_HI : BE_HALF_LO;
                o_wData      = {2{i_storeData[15:0]}};
                o_misaligned = i_addrLo[0];
                o_loadData   = i_unsignedLd ? {16'h0000, w_shifted[15:0]}
                                            : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            SZ_BYTE: begin
                o_be         = BE_BYTE0 << i_addrLo;
                o_wData      = {4{i_storeData[7:0]}};
                o_misaligned = 1'b0;
                o_loadData   = i_unsignedLd ? {24'h000000, w_shifted[7:0]}
                                            : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            default: begin
                o_be         = BE_WORD;
            end
        endcase
    end
`else
    logic w_unusedCfg;

    assign w_unusedCfg  = ^{i_size, i_unsignedLd};
    assign o_be         = BE_WORD;
    assign o_wData      = i_storeData;
    assign o_loadData   = i_rData;
    assign o_misaligned = (i_addrLo != 2'b00);
`endif

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port and stalls upstream until done.
// Subword loads/stores are enabled by defining SUBWORD_ACCESS_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        valid,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  size,
    input  logic        unsignedLd,
    input  logic [31:0] aluResultMem,
    input  logic [31:0] storeData,
    output logic        dmReq,
    output logic        dmWe,
    output logic [31:0] dmAddr,
    output logic [31:0] dmWData,
    output logic [3:0]  dmBe,
    input  logic        dmAck,
    input  logic [31:0] dmRData,
    output logic [31:0] memData,
    output logic        wbWrite,
    output logic        stall,
    output logic        misalign,
    output logic        timeout
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_waitCnt;
    logic             r_dmReq;
    logic             r_dmWe;
    logic [31:0]      r_dmAddr;
    logic [31:0]      r_dmWData;
    logic [3:0]       r_dmBe;
    logic [31:0]      r_memData;
    logic             r_misalign;
    logic             r_timeout;
    logic [1:0]       r_size;
    logic             r_unsignedLd;
    logic             r_isLoad;

    logic             w_memOp;
    logic             w_inIdle;
    logic             w_start;
    logic [1:0]       w_selSize;
    logic             w_selUns;
    logic [1:0]       w_selAddrLo;
    logic [3:0]       w_be;
    logic [31:0]      w_wData;
    logic [31:0]      w_loadData;
    logic             w_misaligned;

    assign w_memOp  = valid & (memRead | memWrite);
    assign w_inIdle = (r_state == ST_IDLE);

    // Live inputs decide enables in IDLE; the latched access drives extraction afterwards.
    assign w_selSize   = w_inIdle ? size : r_size;
    assign w_selUns    = w_inIdle ? unsignedLd : r_unsignedLd;
    assign w_selAddrLo = w_inIdle ? aluResultMem[1:0] : r_dmAddr[1:0];

    mem_lane_align u_laneAlign (
        .i_size       (w_selSize),
        .i_unsignedLd (w_selUns),
        .i_addrLo     (w_selAddrLo),
        .i_storeData  (storeData),
        .i_rData      (dmRData),
        .o_be         (w_be),
        .o_wData      (w_wData),
        .o_loadData   (w_loadData),
        .o_misaligned (w_misaligned)
    );

    assign w_start = w_inIdle & w_memOp & ~w_misaligned;

    assign stall   = rstN & (w_start | (r_state == ST_REQ));
    assign wbWrite = rstN & ((w_inIdle & valid & ~w_start) | (r_state == ST_DONE));

    assign dmReq    = r_dmReq;
    assign dmWe     = r_dmWe;
    assign dmAddr   = r_dmAddr;
    assign dmWData  = r_dmWData;
    assign dmBe     = r_dmBe;
    assign memData  = r_memData;
    assign misalign = r_misalign;
    assign timeout  = r_timeout;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state      <= ST_IDLE;
            r_waitCnt    <= '0;
            r_dmReq      <= 1'b0;
            r_dmWe       <= 1'b0;
            r_dmAddr     <= 32'h0;
            r_dmWData    <= 32'h0;
            r_dmBe       <= BE_NONE;
            r_memData    <= 32'h0;
            r_misalign   <= 1'b0;
            r_timeout    <= 1'b0;
            r_size       <= SZ_WORD;
            r_unsignedLd <= 1'b0;
            r_isLoad     <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_memOp && w_misaligned) begin
                        r_misalign <= 1'b1;
                        r_memData  <= 32'h0;
                    end else if (w_memOp) begin
                        r_dmReq      <= 1'b1;
                        r_dmWe       <= memWrite;
                        r_dmAddr     <= aluResultMem;
                        r_dmWData    <= w_wData;
                        r_dmBe       <= w_be;
                        r_size       <= size;
                        r_unsignedLd <= unsignedLd;
                        r_isLoad     <= memRead & ~memWrite;
                        r_waitCnt    <= '0;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (dmAck) begin
                        r_dmReq   <= 1'b0;
                        r_dmWe    <= 1'b0;
                        r_memData <= r_isLoad ? w_loadData : 32'h0;
                        r_state   <= ST_DONE;
                    end else if (r_waitCnt == CNT_LAST) begin
                        r_dmReq   <= 1'b0;
                        r_dmWe    <= 1'b0;
                        r_memData <= 32'h0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (both SUBWORD_ACCESS_EN builds).
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        valid, memRead, memWrite, unsignedLd, dmAck;
    logic [1:0]  size;
    logic [31:0] aluResultMem, storeData, dmRData;
    logic        dmReq, dmWe, wbWrite, stall, misalign, timeout;
    logic [31:0] dmAddr, dmWData, memData;
    logic [3:0]  dmBe;

    int errors = 0;
    int checks = 0;

    int          oStall, oWb, oReq, oMis, oTo;
    logic [3:0]  oBe;
    logic        oWe;
    logic [31:0] oWData, oAddr, oMem;

    logic [3:0]  expBe;
    logic [31:0] expMem, expWData;
    int          expMis, expReq;

    mem_access_stage #(.WAIT_MAX(15)) dut (
        .clk(clk), .rstN(rstN), .valid(valid), .memRead(memRead), .memWrite(memWrite),
        .size(size), .unsignedLd(unsignedLd), .aluResultMem(aluResultMem),
        .storeData(storeData), .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr),
        .dmWData(dmWData), .dmBe(dmBe), .dmAck(dmAck), .dmRData(dmRData),
        .memData(memData), .wbWrite(wbWrite), .stall(stall), .misalign(misalign),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access; ackOn selects the REQ cycle that sees dmAck (0 = never).
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr,
                             input logic [31:0] sd, input int ackOn,
                             input logic [31:0] rdata);
        bit done = 0;
        valid = 1; memRead = rd; memWrite = wr; size = sz; unsignedLd = uns;
        aluResultMem = addr; storeData = sd; dmAck = 0; dmRData = rdata;
        oStall = 0; oWb = 0; oReq = 0; oMis = 0; oTo = 0;
        oBe = 0; oWe = 0; oWData = 0; oAddr = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (stall) oStall++;
            if (wbWrite) oWb++;
            if (misalign) oMis++;
            if (timeout) oTo++;
            if (dmReq) begin
                oReq++;
                if (oReq == 1) begin
                    oBe = dmBe; oWe = dmWe; oWData = dmWData; oAddr = dmAddr;
                end
            end
            dmAck = dmReq && (oReq == ackOn);
            if (wbWrite) done = 1;
            step();
        end
        valid = 0; memRead = 0; memWrite = 0; dmAck = 0;
        #1;
        if (misalign) oMis++;
        if (timeout) oTo++;
        oMem = memData;
        step();
    endtask

    task automatic test_reset();
        rstN = 0; valid = 1; memRead = 1; memWrite = 0; size = SZ_WORD; unsignedLd = 0;
        aluResultMem = 32'h100; storeData = 0; dmAck = 0; dmRData = 0;
        step(); step();
        checks++;
        if ({dmReq, dmWe, dmBe, misalign, timeout} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b required 00000000", {dmReq, dmWe, dmBe, misalign, timeout});
        end
        checks++;
        if ({dmAddr, dmWData, memData} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: addr=%h wdata=%h mem=%h required all 0", dmAddr, dmWData, memData);
        end
        checks++;
        if ({stall, wbWrite} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_stall_wb: got %b required 00", {stall, wbWrite});
        end
        valid = 0; memRead = 0;
        rstN = 1;
        step();
    endtask

    task automatic test_passthrough();
        valid = 1; memRead = 0; memWrite = 0;
        #1;
        checks++;
        if ({stall, wbWrite, dmReq} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL nonmem_op: stall/wb/req=%b required 010", {stall, wbWrite, dmReq});
        end
        step();
        valid = 0; dmAck = 1; dmRData = 32'hA5A5A5A5;
        #1;
        checks++;
        if ({stall, wbWrite} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_invalid: stall/wb=%b required 00", {stall, wbWrite});
        end
        step();
        dmAck = 0;
        checks++;
        if ({memData, dmReq} !== {32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL idle_ack_ignored: mem=%h req=%b required 0/0", memData, dmReq);
        end
    endtask

    task automatic test_word_load();
        do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        checks++;
        if (oMem !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL word_load_data: got %h required deadbeef", oMem);
        end
        checks++;
        if (oStall !== 4 || oWb !== 1 || oReq !== 3) begin
            errors++;
            $display("[TB] FAIL word_load_timing: stall=%0d wb=%0d req=%0d required 4/1/3", oStall, oWb, oReq);
        end
        checks++;
        if ({oAddr, oBe, oWe} !== {32'h100, 4'b1111, 1'b0}) begin
            errors++;
            $display("[TB] FAIL word_load_port: addr=%h be=%b we=%b required 100/1111/0", oAddr, oBe, oWe);
        end
    endtask

    task automatic test_byte_load();
`ifdef SUBWORD_ACCESS_EN
        expBe = 4'b1000; expMem = 32'hFFFFFF80; expMis = 0; expReq = 1;
`else
        expBe = 4'b0000; expMem = 32'h0; expMis = 1; expReq = 0;
`endif
        do_access(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 1, 32'h80000000);
        checks++;
        if (oMem !== expMem || oBe !== expBe || oMis !== expMis || oReq !== expReq || oWb !== 1) begin
            errors++;
            $display("[TB] FAIL byte_load_signed: mem=%h be=%b mis=%0d req=%0d wb=%0d required %h/%b/%0d/%0d/1",
                     oMem, oBe, oMis, oReq, oWb, expMem, expBe, expMis, expReq);
        end
`ifdef SUBWORD_ACCESS_EN
        expMem = 32'h00000080;
`endif
        do_access(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 2, 32'h80000000);
        checks++;
        if (oMem !== expMem || oMis !== expMis || oWb !== 1) begin
            errors++;
            $display("[TB] FAIL byte_load_unsigned: mem=%h mis=%0d wb=%0d required %h/%0d/1", oMem, oMis, oWb, expMem, expMis);
        end
    endtask

    task automatic test_half_access();
`ifdef SUBWORD_ACCESS_EN
        expBe = 4'b1100; expWData = 32'hABCDABCD; expMis = 0; expReq = 1;
`else
        expBe = 4'b0000; expWData = 32'h0; expMis = 1; expReq = 0;
`endif
        do_access(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h202, 32'h1234ABCD, 1, 32'h0);
        checks++;
        if (oBe !== expBe || oWData !== expWData || oWe !== (expReq == 1) || oMis !== expMis) begin
            errors++;
            $display("[TB] FAIL half_store: be=%b wdata=%h we=%b mis=%0d required %b/%h/%0d/%0d",
                     oBe, oWData, oWe, oMis, expBe, expWData, expReq, expMis);
        end
`ifdef SUBWORD_ACCESS_EN
        expMem = 32'hFFFF8001;
`else
        expMem = 32'h0;
`endif
        do_access(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h202, 32'h0, 1, 32'h80011234);
        checks++;
        if (oMem !== expMem || oBe !== expBe) begin
            errors++;
            $display("[TB] FAIL half_load: mem=%h be=%b required %h/%b", oMem, oBe, expMem, expBe);
        end
`ifdef SUBWORD_ACCESS_EN
        expBe = 4'b0010; expWData = 32'hA5A5A5A5;
`endif
        do_access(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h000000A5, 1, 32'h0);
        checks++;
        if (oBe !== expBe || oWData !== expWData) begin
            errors++;
            $display("[TB] FAIL byte_store: be=%b wdata=%h required %b/%h", oBe, oWData, expBe, expWData);
        end
    endtask

    task automatic test_store_priority();
        do_access(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h204, 32'hCAFEF00D, 2, 32'h55555555);
        checks++;
        if ({oWe, oBe, oWData, oAddr} !== {1'b1, 4'b1111, 32'hCAFEF00D, 32'h204}) begin
            errors++;
            $display("[TB] FAIL rw_store: we=%b be=%b wdata=%h addr=%h required 1/1111/cafef00d/204", oWe, oBe, oWData, oAddr);
        end
        checks++;
        if (oMem !== 32'h0 || oWb !== 1) begin
            errors++;
            $display("[TB] FAIL rw_store_memdata: mem=%h wb=%0d required 0/1", oMem, oWb);
        end
    endtask

    task automatic test_misalign();
        do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 1, 32'h0BADF00D);
        do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, 1, 32'h11111111);
        checks++;
        if (oMis !== 1 || oReq !== 0 || oMem !== 32'h0 || oStall !== 0 || oWb !== 1) begin
            errors++;
            $display("[TB] FAIL misalign_word: mis=%0d req=%0d mem=%h stall=%0d wb=%0d required 1/0/0/0/1",
                     oMis, oReq, oMem, oStall, oWb);
        end
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 1, 32'h77777777);
        do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h108, 32'h0, 0, 32'h99999999);
        checks++;
        if (oTo !== 1 || oReq !== 15 || oMem !== 32'h0 || oWb !== 1 || oStall !== 16) begin
            errors++;
            $display("[TB] FAIL timeout: to=%0d req=%0d mem=%h wb=%0d stall=%0d required 1/15/0/1/16",
                     oTo, oReq, oMem, oWb, oStall);
        end
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10C, 32'h0, 1, 32'h13579BDF);
        checks++;
        if (oMem !== 32'h13579BDF || oStall !== 2 || oReq !== 1 || oAddr !== 32'h10C) begin
            errors++;
            $display("[TB] FAIL min_latency: mem=%h stall=%0d req=%0d addr=%h required 13579bdf/2/1/10c",
                     oMem, oStall, oReq, oAddr);
        end
        do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h110, 32'h0, 2, 32'h2468ACE0);
        checks++;
        if (oMem !== 32'h2468ACE0 || oStall !== 3) begin
            errors++;
            $display("[TB] FAIL second_load: mem=%h stall=%0d required 2468ace0/3", oMem, oStall);
        end
    endtask

    task automatic test_reset_in_req();
        valid = 1; memRead = 1; memWrite = 0; size = SZ_WORD; unsignedLd = 0;
        aluResultMem = 32'h300; dmAck = 0;
        step(); step();
        checks++;
        if (dmReq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_req_active: req=%b required 1", dmReq);
        end
        rstN = 0; valid = 0; memRead = 0;
        step();
        checks++;
        if ({dmReq, stall, wbWrite} !== 3'b000 || memData !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_req_drop: req/stall/wb=%b mem=%h required 000/0", {dmReq, stall, wbWrite}, memData);
        end
        rstN = 1; dmAck = 1; dmRData = 32'h12345678;
        #1;
        checks++;
        if (wbWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_late_ack_wb: wb=%b required 0", wbWrite);
        end
        step();
        dmAck = 0;
        #1;
        checks++;
        if ({memData, wbWrite, dmReq} !== {32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rst_late_ack: mem=%h wb=%b req=%b required 0/0/0", memData, wbWrite, dmReq);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_word_load();
        test_byte_load();
        test_half_access();
        test_store_priority();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_in_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum cycles in REQ without dmAck before timeout.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-003 SHALL have port rstN, input, 1: synchronous reset, active-low.
REQ-004 SHALL have port valid, input, 1: MEM-stage instruction valid.
REQ-005 SHALL have ports memRead and memWrite, input, 1 each: load and store controls.
REQ-006 SHALL have port size, input, 2: access size, 00 word, 01 half, 10 byte.
REQ-007 SHALL have port unsignedLd, input, 1: zero-extend subword loads.
REQ-008 SHALL have ports aluResultMem, input, 32 (address) and storeData, input, 32.
REQ-009 SHALL have ports dmReq, dmWe, output, 1 each; dmAddr, dmWData, output, 32 each; dmBe, output, 4; dmAck, input, 1; dmRData, input, 32.
REQ-010 SHALL have port memData, output, 32: load result to the MEM/WB register.
REQ-011 SHALL have port wbWrite, output, 1: write enable to the MEM/WB register.
REQ-012 SHALL have port stall, output, 1: hold request to upstream stages.
REQ-013 SHALL have ports misalign and timeout, output, 1 each: single-cycle error pulses.

Function
REQ-014 SHALL implement FSM IDLE, REQ, DONE.
REQ-015 IDLE, with no valid memory op: stall=0, wbWrite=valid, state stays IDLE; no dmReq.
REQ-016 IDLE, valid aligned memRead or memWrite: stall=1 combinationally that cycle; latch address, data, byte enables and dmWe; go to REQ.
REQ-017 REQ: dmReq=1 and dmAddr/dmWData/dmBe/dmWe held stable; stall=1; on dmAck go to DONE and register extended load data into memData (0 for stores).
REQ-018 DONE: stall=0, wbWrite=1 for exactly one cycle; go to IDLE; minimum op latency is 2 cycles after acceptance.
REQ-019 Wait counter SHALL clear on entering REQ; if WAIT_MAX cycles elapse without dmAck, pulse timeout, set memData=0, drop dmReq and go to DONE.
REQ-020 Misaligned access (word addr[1:0]!=0, half addr[0]!=0) SHALL pulse misalign, issue no request, set memData=0, wbWrite=1, stall=0.
REQ-021 When memRead and memWrite are both 1, the store SHALL be performed and the read ignored.
REQ-022 Byte enables: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0], little-endian.
REQ-023 Stores SHALL replicate the low half or byte across all lanes of dmWData.
REQ-024 Loads SHALL extract the addressed lane and sign-extend, or zero-extend when unsignedLd=1.
REQ-025 A dmAck arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-026 With rstN=0 at posedge clk: state=IDLE, memData=0, dmReq=0, dmWe=0, dmAddr=0, dmWData=0, dmBe=0, wait counter=0, misalign=0, timeout=0.
REQ-027 While rstN=0, stall=0 and wbWrite=0.
REQ-028 Reset during REQ SHALL deassert dmReq at that edge and abandon the access; a late dmAck is then ignored.

Configuration
REQ-029 Macro SUBWORD_ACCESS_EN defined: size and unsignedLd honoured as in REQ-020 to REQ-024.
REQ-030 Macro SUBWORD_ACCESS_EN undefined: size and unsignedLd ignored; all accesses are word, dmBe=1111, misaligned only when addr[1:0]!=0.

Structure
REQ-031 Package mem_stage_pkg SHALL hold the FSM state type, size encodings (SZ_WORD, SZ_HALF, SZ_BYTE), and the byte-enable constants.
REQ-032 Sub-module mem_lane_align SHALL implement combinational byte-enable generation, store replication and load extraction/extension.

Verification
REQ-033 Word load at addr 0x100, dmAck on 3rd REQ cycle, dmRData=0xDEADBEEF -> memData=0xDEADBEEF, wbWrite=1 for one cycle, stall high for 4 cycles.
REQ-034 Byte load at addr 0x103, dmRData=0x80000000, unsignedLd=0 -> dmBe=1000, memData=0xFFFFFF80; with unsignedLd=1 -> 0x00000080.
REQ-035 Half store at addr 0x202, storeData=0x1234ABCD -> dmWe=1, dmBe=1100, dmWData=0xABCDABCD.
REQ-036 Word load at addr 0x101 -> misalign pulses once, dmReq never asserted, memData=0, stall=0.
REQ-037 Load with dmAck held low -> timeout pulses after 15 REQ cycles, memData=0, FSM returns to IDLE.
REQ-038 rstN=0 while in REQ -> dmReq=0 on the next edge; a dmAck one cycle later leaves memData=0 and wbWrite=0.
